load_updown_counter: RTL and testbench
======================================

LOAD_UPDOWN_COUNTER -- requirements
Module: load_updown_counter

Interface
- REQ-001: Parameter HOW_MANY_BITS SHALL be declared, default 4; it sets the counter width N (N=3 counts 0..7, N=4 counts 0..15); legal range 1..32.
- REQ-002: One clock; reset is asynchronous and active-low.
- REQ-003: CLK  input  1  rising-edge clock for all state.
- REQ-004: RST  input  1  asynchronous, active-low reset.
- REQ-005: IN  input  N  parallel load value.
- REQ-006: LOAD  input  1  load enable; 1 = OUT takes IN at the next edge.
- REQ-007: UP_or_DOWN  input  1  count direction; 0 = up, 1 = down.
- REQ-008: START_or_STOP  input  1  run enable; 1 = run, 0 = hold.
- REQ-009: OUT  output  N  registered counter value.
- REQ-010: WRAP  output  1  registered one-cycle pulse, high in the cycle after a count step crosses the boundary (max->0 up, 0->max down).

Function
- REQ-011: All state SHALL update only on the rising edge of CLK, except reset.
- REQ-012: Per-edge priority SHALL be: START_or_STOP=0 holds OUT; else LOAD=1 loads IN; else count.
- REQ-013: Hold SHALL keep OUT unchanged and drive WRAP=0, regardless of LOAD and UP_or_DOWN.
- REQ-014: Load SHALL set OUT=IN with 1-cycle latency and drive WRAP=0, even if IN equals a boundary value.
- REQ-015: Count up SHALL set OUT=OUT+1 modulo 2^N; 2^N-1 -> 0 SHALL set WRAP=1 for one cycle.
- REQ-016: Count down SHALL set OUT=OUT-1 modulo 2^N; 0 -> 2^N-1 SHALL set WRAP=1 for one cycle.
- REQ-017: Any X/unknown on UP_or_DOWN SHALL be treated as count up.
- REQ-018: A direction change SHALL take effect at the first edge it is sampled; no extra latency and no skipped value.
- REQ-019: Inputs SHALL be sampled synchronously; no combinational path from any input to OUT or WRAP.

Reset
- REQ-020: RST=0 SHALL immediately, without waiting for CLK, force OUT=0 and WRAP=0.
- REQ-021: While RST=0, all other inputs SHALL be ignored.
- REQ-022: After RST rises, the first rising edge SHALL apply the normal priority of REQ-012.
- REQ-023: Reset asserted mid-count, mid-load or during hold SHALL abort that operation; no pending value survives reset.

Structure
- REQ-024: A shared package SHALL hold the direction enum (DIR_UP=1'b0, DIR_DOWN=1'b1) and the default width constant (4).
- REQ-025: The design SHALL be one flat module with one sequential process and one next-value combinational block; no sub-module is required.

Verification
- REQ-026: N=4, RST=0 pulsed mid-count at OUT=9 -> OUT=0 immediately, before the next CLK edge; WRAP=0.
- REQ-027: N=4, run, up, LOAD=0 from 0 for 17 edges -> OUT 1..15, 0, 1; WRAP=1 only in the cycle OUT=0.
- REQ-028: N=4, run, down from OUT=2 for 4 edges -> OUT 1, 0, 15, 14; WRAP=1 only in the cycle OUT=15.
- REQ-029: LOAD=1, IN=10, run -> OUT=10 after one edge; with LOAD=1, IN=10 and START_or_STOP=0 -> OUT unchanged.
- REQ-030: Hold at OUT=7 for 5 edges while toggling UP_or_DOWN and LOAD -> OUT=7 throughout; WRAP=0.
- REQ-031: N=3, run, up for 9 edges from 0 -> OUT wraps 7 -> 0 with a WRAP pulse; direction change at OUT=5 -> next OUT=4.

Source files
------------

// File: rtl/load_updown_counter_pkg.sv
// Shared types and constants for the loadable up/down counter.
// Direction encoding matches the UP_or_DOWN pin level.
package load_updown_counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/load_updown_counter_if.sv
// Control/data bundle between a counter driver and the counter.
// Master drives controls and load data; slave returns count and wrap.
interface load_updown_counter_if
  import load_updown_counter_pkg::*;
#(
  parameter int HOW_MANY_BITS = DEF_WIDTH
);

  logic [HOW_MANY_BITS-1:0] IN;
  logic                     LOAD;
  logic                     UP_or_DOWN;
  logic                     START_or_STOP;
  logic [HOW_MANY_BITS-1:0] OUT;
  logic                     WRAP;

  modport master (
    output IN,
    output LOAD,
    output UP_or_DOWN,
    output START_or_STOP,
    input  OUT,
    input  WRAP
  );

  modport slave (
    input  IN,
    input  LOAD,
    input  UP_or_DOWN,
    input  START_or_STOP,
    output OUT,
    output WRAP
  );

endinterface

// File: rtl/load_updown_counter.sv
// Loadable modulo-2^N up/down counter with a one-cycle wrap pulse.
// Priority per edge: hold, then load, then count.
module load_updown_counter
  import load_updown_counter_pkg::*;
#(
  parameter int HOW_MANY_BITS = DEF_WIDTH
) (
  input logic                  CLK,
  input logic                  RST,
  load_updown_counter_if.slave bus
);

  localparam int N = HOW_MANY_BITS;
  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] MAX  = '1;

  logic [N-1:0] cnt;
  logic [N-1:0] cnt_nxt;
  logic         wrap_q;
  logic         wrap_nxt;
  dir_e         dir;

  // Anything other than a solid 1 counts up.
  always_comb begin
    dir = DIR_UP;
    if (bus.UP_or_DOWN == 1'b1) dir = DIR_DOWN;
  end

  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    unique case (1'b1)
      !bus.START_or_STOP: begin
        cnt_nxt = cnt;
      end
      bus.START_or_STOP && bus.LOAD: begin
        cnt_nxt = bus.IN;
      end
      bus.START_or_STOP && !bus.LOAD
        && (dir == DIR_DOWN): begin
        cnt_nxt  = cnt - ONE;
        wrap_nxt = (cnt == ZERO);
      end
      default: begin
        cnt_nxt  = cnt + ONE;
        wrap_nxt = (cnt == MAX);
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt    <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.OUT  = cnt;
  assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_load_updown_counter.sv
// Self-checking bench: vector table, corner sequences, random vs model.
// Covers N=4 and an N=3 instance.
module tb_load_updown_counter;

  logic clk;
  logic rst_n;

  int n_chk;
  int n_fail;

  typedef struct {
    int in;
    bit load;
    bit dir;
    bit run;
    int eo;
    bit ew;
  } vec_t;

  vec_t vecs[$];

  load_updown_counter_if #(.HOW_MANY_BITS(4)) b4 ();
  load_updown_counter_if #(.HOW_MANY_BITS(3)) b3 ();

  load_updown_counter #(.HOW_MANY_BITS(4)) dut4 (
    .CLK (clk),
    .RST (rst_n),
    .bus (b4)
  );

  load_updown_counter #(.HOW_MANY_BITS(3)) dut3 (
    .CLK (clk),
    .RST (rst_n),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(int in, bit load, bit dir, bit run);
    b4.IN            = 4'(in);
    b4.LOAD          = load;
    b4.UP_or_DOWN    = dir;
    b4.START_or_STOP = run;
  endtask

  task automatic drv3(int in, bit load, bit dir, bit run);
    b3.IN            = 3'(in);
    b3.LOAD          = load;
    b3.UP_or_DOWN    = dir;
    b3.START_or_STOP = run;
  endtask

  function automatic void mk(int in, bit load, bit dir,
                             bit run, int eo, bit ew);
    vec_t v;
    v.in = in; v.load = load; v.dir = dir;
    v.run = run; v.eo = eo; v.ew = ew;
    vecs.push_back(v);
  endfunction

  initial begin
    int mo;
    bit mw;
    int r_in;
    bit r_ld, r_dir, r_run;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drv4(5, 1, 0, 1);
    drv3(0, 0, 0, 0);

    // Reset holds OUT at zero even with load/run active.
    #1;
    chk("rst_async_out", b4.OUT, 0);
    chk("rst_async_wrap", b4.WRAP, 0);
    tick();
    tick();
    chk("rst_hold_out", b4.OUT, 0);
    chk("rst_hold_wrap", b4.WRAP, 0);
    drv4(0, 0, 0, 1);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++)
      mk(0, 0, 0, 1, (i + 1) % 16, i == 15);
    mk(2, 1, 0, 1, 2, 0);
    mk(0, 0, 1, 1, 1, 0);
    mk(0, 0, 1, 1, 0, 0);
    mk(0, 0, 1, 1, 15, 1);
    mk(0, 0, 1, 1, 14, 0);
    mk(10, 1, 0, 1, 10, 0);
    mk(7, 1, 0, 1, 7, 0);
    mk(10, 1, 1, 0, 7, 0);
    for (int i = 0; i < 5; i++)
      mk(3, i % 2, (i % 2) == 0, 0, 7, 0);
    mk(15, 1, 0, 1, 15, 0);
    mk(0, 1, 1, 1, 0, 0);
    mk(0, 0, 0, 1, 1, 0);
    mk(0, 0, 1, 1, 0, 0);
    mk(0, 0, 1, 1, 15, 1);
    mk(0, 0, 0, 1, 0, 1);
    mk(0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drv4(vecs[i].in, vecs[i].load, vecs[i].dir, vecs[i].run);
      tick();
      chk($sformatf("vec%0d_out", i), b4.OUT, vecs[i].eo);
      chk($sformatf("vec%0d_wrap", i), b4.WRAP, vecs[i].ew);
    end

    // Async reset mid-count at 9, seen before the next edge.
    drv4(8, 1, 0, 1);
    tick();
    drv4(0, 0, 0, 1);
    tick();
    chk("pre_rst_out", b4.OUT, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midcount_rst_out", b4.OUT, 0);
    chk("midcount_rst_wrap", b4.WRAP, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_first_edge", b4.OUT, 1);

    // A load set up before reset must not survive it.
    drv4(5, 1, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("load_abort_async", b4.OUT, 0);
    tick();
    chk("load_abort_edge", b4.OUT, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("load_after_rst", b4.OUT, 5);

    // Random traffic against an arithmetic model.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rand_rst", b4.OUT, 0);
    #2;
    rst_n = 1'b1;
    mo = 0;
    mw = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r_in  = int'($urandom_range(0, 15));
      r_ld  = ($urandom_range(0, 3) == 0);
      r_dir = 1'($urandom);
      r_run = ($urandom_range(0, 3) != 0);
      drv4(r_in, r_ld, r_dir, r_run);
      if (!r_run) begin
        mw = 1'b0;
      end else if (r_ld) begin
        mo = r_in;
        mw = 1'b0;
      end else if (r_dir) begin
        mw = (mo == 0);
        mo = (mo + 15) % 16;
      end else begin
        mw = (mo == 15);
        mo = (mo + 1) % 16;
      end
      tick();
      chk($sformatf("rand%0d_out", i), b4.OUT, mo);
      chk($sformatf("rand%0d_wrap", i), b4.WRAP, mw);
    end

    // Three-bit instance: wrap at 7 and immediate reversal.
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drv4(0, 0, 0, 0);
    drv3(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("n3_up%0d_out", i), b3.OUT, (i + 1) % 8);
      chk($sformatf("n3_up%0d_wrap", i), b3.WRAP, i == 7);
    end
    for (int i = 0; i < 4; i++) tick();
    chk("n3_at5", b3.OUT, 5);
    drv3(0, 0, 1, 1);
    tick();
    chk("n3_reverse_out", b3.OUT, 4);
    chk("n3_reverse_wrap", b3.WRAP, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
